// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : spi_pkg                                                   |
// | Description : Shared types and defaults for the SPI transmit path.      |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  // Word width of the SPI master's din port
  localparam int SPI_DATA_W = 12;

  typedef logic [SPI_DATA_W-1:0] spi_word_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    GAP        = 3'd4
  } txq_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// | Module      : sync_fifo                                                 |
// | Description : Single-clock circular FIFO with occupancy count. Writes   |
// |               while full are dropped and flagged on ovf.               |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_do_push;
  logic              w_do_pop;

  // full/empty come from the registered level, so a pop in the same cycle
  // never makes room for a write that arrived while full
  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign ovf       = push & full;
  assign rdata     = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_tx_queue.sv
// ---------------------------------------------------------------------------
// | Module      : spi_tx_queue                                              |
// | Description : Command queue feeding the SPI master: issues one word per |
// |               frame as a newd pulse, tracks cs for frame start/end,    |
// |               enforces an inter-frame gap and watches for stalls.      |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module spi_tx_queue
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int DEPTH       = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       newd,
  output logic [DATA_W-1:0]          din,
  input  logic                       cs_in,
  output logic                       busy,
  input  logic                       err_clr,
  output logic                       err_ovf,
  output logic                       err_tmo,
  output logic [15:0]                sent_cnt
);

  localparam int TMR_MAX  = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  // GAP_CYC of 0 behaves as a single pass-through cycle
  localparam int GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

  txq_state_t        r_state;
  txq_state_t        w_state_next;
  logic [TMR_W-1:0]  r_timer;
  logic              r_cs;
  logic              w_pop;
  logic              w_tmo_evt;
  logic              w_frame_done;
  logic              w_timer_last;
  logic [DATA_W-1:0] w_head;
  logic              w_ovf_evt;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (w_pop),
    .wdata (wr_data),
    .rdata (w_head),
    .full  (full),
    .empty (empty),
    .level (level),
    .ovf   (w_ovf_evt)
  );

  assign w_timer_last = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the frame-done and timeout events it decides
  always_comb begin
    w_state_next = r_state;
    w_tmo_evt    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = WAIT_START;
      end
      WAIT_START: begin
        if (!r_cs) begin
          w_state_next = WAIT_END;
        end else if (w_timer_last) begin
          w_tmo_evt    = 1'b1;
          w_state_next = IDLE;
        end
      end
      WAIT_END: begin
        if (r_cs) begin
          w_frame_done = 1'b1;
          w_state_next = GAP;
        end else if (w_timer_last) begin
          w_tmo_evt    = 1'b1;
          w_state_next = IDLE;
        end
      end
      GAP: begin
        if (r_timer == TMR_W'(GAP_LAST)) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    newd  = (r_state == ISSUE);
    busy  = (r_state != IDLE);
    w_pop = (r_state == IDLE) && !empty;
  end

  // Datapath: cs sampling, wait timer, held word, error flags, frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs     <= 1'b1;
      r_timer  <= '0;
      din      <= '0;
      err_ovf  <= 1'b0;
      err_tmo  <= 1'b0;
      sent_cnt <= '0;
    end else begin
      r_cs <= cs_in;
      // Timer restarts on every state entry
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_pop) begin
        din <= w_head;
      end
      // A new error event takes priority over a simultaneous clear
      if (w_ovf_evt) begin
        err_ovf <= 1'b1;
      end else if (err_clr) begin
        err_ovf <= 1'b0;
      end
      if (w_tmo_evt) begin
        err_tmo <= 1'b1;
      end else if (err_clr) begin
        err_tmo <= 1'b0;
      end
      if (w_frame_done) begin
        sent_cnt <= sent_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_queue.sv
// ---------------------------------------------------------------------------
// | Module      : tb_spi_tx_queue                                           |
// | Description : Directed self-checking bench for spi_tx_queue with a      |
// |               simple SPI master model and an expected-word scoreboard. |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_tx_queue;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  spi_word_t   wr_data;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        newd;
  spi_word_t   din;
  logic        cs_in;
  logic        busy;
  logic        err_clr;
  logic        err_ovf;
  logic        err_tmo;
  logic [15:0] sent_cnt;

  // cs source: master model, or a level forced by the stimulus
  logic cs_sel;
  logic cs_force;
  logic cs_model;
  assign cs_in = cs_sel ? cs_force : cs_model;

  int        n_checks = 0;
  int        n_fail   = 0;
  spi_word_t exp_q[$];

  spi_tx_queue dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .newd     (newd),
    .din      (din),
    .cs_in    (cs_in),
    .busy     (busy),
    .err_clr  (err_clr),
    .err_ovf  (err_ovf),
    .err_tmo  (err_tmo),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input spi_word_t w, input bit expect_sent);
    wr_en   = 1'b1;
    wr_data = w;
    if (expect_sent) exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    err_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || !empty) && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_wait_busy", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: every newd pulse must carry the next expected word
  initial begin
    spi_word_t e;
    forever begin
      @(negedge clk);
      if (newd === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("stray_newd", {31'd0, newd}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_din", 32'(din), 32'(e));
        end
      end
    end
  end

  // SPI master model: lowers cs two cycles after newd, holds it for six
  initial begin
    spi_word_t cap;
    cs_model = 1'b1;
    forever begin
      @(negedge clk);
      if (newd === 1'b1 && !cs_sel) begin
        cap = din;
        tick(2);
        cs_model = 1'b0;
        repeat (6) begin
          tick(1);
          chk("din_stable", 32'(din), 32'(cap));
        end
        cs_model = 1'b1;
      end
    end
  end

  initial begin
    int n;
    cs_sel   = 1'b0;
    cs_force = 1'b1;
    wr_data  = '0;

    // Reset state
    do_reset();
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_newd", {31'd0, newd}, 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_errs", {30'd0, err_ovf, err_tmo}, 32'd0);
    chk("rst_sent", 32'(sent_cnt), 32'd0);

    // Single frame with a cooperating master
    push(12'hA5C, 1'b1);
    chk("t1_newd_pre", {31'd0, newd}, 32'd0);
    tick(1);
    chk("t1_newd_hi", {31'd0, newd}, 32'd1);
    chk("t1_din", 32'(din), 32'hA5C);
    tick(1);
    chk("t1_newd_one", {31'd0, newd}, 32'd0);
    n = 0;
    while (sent_cnt != 16'd1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t1_sent", 32'(sent_cnt), 32'd1);
    chk("t1_din_gap", 32'(din), 32'hA5C);
    tick(3);
    chk("t1_gap_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Stalled master: leader times out in WAIT_START while the queue fills
    do_reset();
    cs_sel   = 1'b1;
    cs_force = 1'b1;
    push(12'h0AA, 1'b1);
    tick(2);
    for (int i = 1; i <= 8; i++) push(spi_word_t'(i), 1'b1);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_level", 32'(level), 32'd8);
    push(12'h009, 1'b0);
    chk("t2_ovf", {31'd0, err_ovf}, 32'd1);
    chk("t2_level_ovf", 32'(level), 32'd8);
    tick(1014);
    chk("t3_tmo_early", {31'd0, err_tmo}, 32'd0);
    chk("t3_busy_wait", {31'd0, busy}, 32'd1);
    cs_sel = 1'b0;
    tick(1);
    chk("t3_tmo", {31'd0, err_tmo}, 32'd1);
    chk("t3_sent0", 32'(sent_cnt), 32'd0);
    wait_idle(3000);
    chk("t2_sent8", 32'(sent_cnt), 32'd8);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Timeout in WAIT_END, error clear, and set-beats-clear on overflow
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_clr", {30'd0, err_ovf, err_tmo}, 32'd0);
    cs_sel   = 1'b1;
    cs_force = 1'b1;
    push(12'h155, 1'b1);
    tick(2);
    cs_force = 1'b0;
    tick(2);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    tick(1023);
    chk("t4_tmo_early", {31'd0, err_tmo}, 32'd0);
    tick(1);
    chk("t4_tmo", {31'd0, err_tmo}, 32'd1);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_sent", 32'(sent_cnt), 32'd8);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_tmo_clr", {31'd0, err_tmo}, 32'd0);
    cs_force = 1'b1;
    for (int i = 0; i < 9; i++) push(spi_word_t'(12'h200 + i), 1'b1);
    chk("t4_full", {31'd0, full}, 32'd1);
    wr_en   = 1'b1;
    wr_data = 12'h3FF;
    err_clr = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    err_clr = 1'b0;
    chk("t4_ovf_wins", {31'd0, err_ovf}, 32'd1);

    // Reset while in WAIT_END with words queued
    do_reset();
    cs_force = 1'b1;
    push(12'h321, 1'b1);
    tick(2);
    cs_force = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) push(spi_word_t'(12'h400 + i), 1'b1);
    chk("t5_level3", 32'(level), 32'd3);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    cs_force = 1'b1;
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    chk("t5_newd", {31'd0, newd}, 32'd0);
    chk("t5_busy0", {31'd0, busy}, 32'd0);
    chk("t5_din", 32'(din), 32'd0);
    repeat (5) begin
      tick(1);
      chk("t5_no_newd", {31'd0, newd}, 32'd0);
    end
    cs_sel = 1'b0;

    // Push coinciding with the IDLE pop at level 1
    push(12'h123, 1'b1);
    push(12'h7FF, 1'b1);
    chk("t6_level1", 32'(level), 32'd1);
    wait_idle(500);
    chk("t6_sent", 32'(sent_cnt), 32'd2);
    chk("t6_level0", 32'(level), 32'd0);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
